// File: rtl/txd_pkg.sv
// Shared constants and state type for the WimpFi transmit buffer FSMs.
package txd_pkg;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD0;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    FETCH,
    WAIT,
    SEND,
    DONE
  } txd_rd_state_t;

endpackage

// File: rtl/txd_read_fsm.sv
// Transmit drain: preamble, SFD, then buffer payload to the serializer.
// Pulses done/buf_clear once the last payload byte is accepted.
module txd_read_fsm
  import txd_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int PREAMBLE_LEN = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] byte_count,
  output logic              ren,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_rdy,
  output logic              busy,
  output logic              done,
  output logic              buf_clear
);

  localparam int PW = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  localparam logic [PW-1:0] PLAST = PW'(PREAMBLE_LEN - 1);

  txd_rd_state_t     state, state_d;
  logic [PW-1:0]     pcnt, pcnt_d;
  logic [ADDR_W-1:0] len, len_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] txq, txq_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      pcnt   <= '0;
      len    <= '0;
      r_addr <= '0;
      txq    <= '0;
    end else begin
      state  <= state_d;
      pcnt   <= pcnt_d;
      len    <= len_d;
      r_addr <= addr_d;
      txq    <= txq_d;
    end
  end

  always_comb begin
    state_d   = state;
    pcnt_d    = pcnt;
    len_d     = len;
    addr_d    = r_addr;
    txq_d     = txq;
    ren       = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = txq;
    done      = 1'b0;
    buf_clear = 1'b0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (start && byte_count != '0) begin
          len_d   = byte_count;
          pcnt_d  = '0;
          addr_d  = '0;
          state_d = PRE;
        end
      end
      PRE: begin
        tx_valid = 1'b1;
        tx_data  = DATA_W'(PREAMBLE_BYTE);
        if (tx_rdy) begin
          if (pcnt == PLAST) state_d = SFD;
          else pcnt_d = pcnt + 1'b1;
        end
      end
      SFD: begin
        tx_valid = 1'b1;
        tx_data  = DATA_W'(SFD_BYTE);
        if (tx_rdy) begin
          addr_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        ren     = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        txq_d   = r_data;
        state_d = SEND;
      end
      SEND: begin
        tx_valid = 1'b1;
        if (tx_rdy) begin
          // len is never 0 here, so len-1 cannot underflow
          if (r_addr == len - ADDR_W'(1)) begin
            state_d = DONE;
          end else begin
            addr_d  = r_addr + 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        buf_clear = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_txd_read_fsm.sv
// Directed bench for txd_read_fsm with a byte/address scoreboard.
module tb_txd_read_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] byte_count = '0;
  logic       ren;
  logic [7:0] r_addr;
  logic [7:0] r_data = '0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_rdy = 1'b1;
  logic       busy;
  logic       done;
  logic       buf_clear;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_q [$];
  logic [7:0] addr_q [$];
  int xfer_cnt = 0;
  int ren_cnt = 0;
  int done_cnt = 0;
  int stall_cnt = 0;
  logic       p_stall = 1'b0;
  logic [7:0] p_data = '0;

  txd_read_fsm #(.ADDR_W(8), .DATA_W(8), .PREAMBLE_LEN(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_count(byte_count), .ren(ren), .r_addr(r_addr),
    .r_data(r_data), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_rdy(tx_rdy), .busy(busy), .done(done),
    .buf_clear(buf_clear)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (ren) r_data <= mem[r_addr];

  always @(negedge clk) begin
    if (reset) begin
      if (p_stall) begin
        checks++;
        assert (tx_valid === 1'b1 && tx_data === p_data) else begin
          failures++;
          $error("FAIL hold valid=%0b data=%h want 1/%h",
                 tx_valid, tx_data, p_data);
        end
      end
      if (tx_valid && tx_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $error("FAIL extra_byte got %h want none", tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          assert (tx_data === e) else begin
            failures++;
            $error("FAIL byte got %h want %h", tx_data, e);
          end
        end
        xfer_cnt++;
      end
      if (tx_valid && !tx_rdy) stall_cnt++;
      p_stall = tx_valid && !tx_rdy;
      p_data  = tx_data;
      if (ren) begin
        ren_cnt++;
        checks++;
        if (addr_q.size() == 0) begin
          failures++;
          $error("FAIL extra_ren addr %0d want none", r_addr);
        end else begin
          logic [7:0] a;
          a = addr_q.pop_front();
          assert (r_addr === a) else begin
            failures++;
            $error("FAIL r_addr got %0d want %0d", r_addr, a);
          end
        end
      end
      if (done || buf_clear) begin
        checks++;
        assert (done === 1'b1 && buf_clear === 1'b1 && busy === 1'b1)
        else begin
          failures++;
          $error("FAIL done_pulse d/bc/busy=%b%b%b want 111",
                 done, buf_clear, busy);
        end
        if (done) done_cnt++;
      end
    end else begin
      p_stall = 1'b0;
    end
  end

  task automatic check(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic start_frame(int n, logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      mem[i] = base + 8'(i * 17);
    end
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hD0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mem[i]);
      addr_q.push_back(8'(i));
    end
    xfer_cnt = 0;
    ren_cnt = 0;
    stall_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    byte_count = 8'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_xfer(int k, string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (xfer_cnt >= k) begin ok = 1'b1; break; end
    end
    check({tag, "_timeout"}, int'(ok), 1);
  endtask

  task automatic wait_valid(string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (tx_valid) begin ok = 1'b1; break; end
    end
    check({tag, "_valid_timeout"}, int'(ok), 1);
  endtask

  task automatic wait_done(string tag, int d0);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    check({tag, "_done_timeout"}, int'(ok), 1);
    @(negedge clk); #1;
    check({tag, "_busy_after"}, int'(busy), 0);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_q_empty"}, exp_q.size() + addr_q.size(), 0);
  endtask

  initial begin
    int d0;
    bit seen;
    // 1: reset
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_outs", int'({ren, tx_valid, busy, done, buf_clear}), 0);
    check("rst_addr", int'(r_addr), 0);
    check("rst_data", int'(tx_data), 0);

    // 2: basic 3-byte frame
    mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3;
    exp_q = '{8'h55, 8'h55, 8'hD0, 8'hA1, 8'hB2, 8'hC3};
    addr_q = '{8'd0, 8'd1, 8'd2};
    xfer_cnt = 0; ren_cnt = 0; d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; byte_count = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check("lat_valid", int'(tx_valid), 1);
    check("lat_busy", int'(busy), 1);
    wait_done("t2", d0);
    check("t2_ren", ren_cnt, 3);

    // 3: backpressure on B2
    exp_q = '{8'h55, 8'h55, 8'hD0, 8'hA1, 8'hB2, 8'hC3};
    addr_q = '{8'd0, 8'd1, 8'd2};
    xfer_cnt = 0; ren_cnt = 0; stall_cnt = 0; d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; byte_count = 8'd3;
    @(negedge clk);
    start = 1'b0;
    wait_xfer(4, "t3");
    @(posedge clk); #1;
    tx_rdy = 1'b0;
    wait_valid("t3");
    check("t3_b2", int'(tx_data), 8'hB2);
    repeat (4) @(posedge clk);
    #1 tx_rdy = 1'b1;
    wait_done("t3", d0);
    check("t3_stalls", stall_cnt, 4);
    check("t3_ren", ren_cnt, 3);

    // 4: zero-length start ignored
    d0 = done_cnt; seen = 1'b0;
    @(negedge clk);
    start = 1'b1; byte_count = 8'd0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || tx_valid || done) seen = 1'b1;
    end
    check("t4_idle", int'(seen), 0);
    check("t4_nodone", done_cnt - d0, 0);

    // 5: start mid-frame ignored
    d0 = done_cnt;
    start_frame(5, 8'h30);
    wait_xfer(5, "t5");
    @(negedge clk);
    start = 1'b1; byte_count = 8'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done("t5", d0);
    check("t5_ren", ren_cnt, 5);
    check("t5_xfers", xfer_cnt, 8);
    repeat (3) @(negedge clk);
    check("t5_no_restart", int'(busy), 0);

    // 6: reset in SEND of byte 1
    d0 = done_cnt;
    start_frame(4, 8'h60);
    wait_xfer(4, "t6");
    @(posedge clk); #1;
    tx_rdy = 1'b0;
    wait_valid("t6");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("t6_valid", int'(tx_valid), 0);
    check("t6_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    addr_q.delete();
    tx_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_nodone", done_cnt - d0, 0);
    start_frame(4, 8'h90);
    wait_done("t6b", d0);
    check("t6b_xfers", xfer_cnt, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
